uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that lets up to NUM_REQ byte producers share one `uarttx` serializer. It sits between the requesters and the transmitter's `newd`/`dintx` inputs. It launches one frame at a time and monitors the serial line and `donetx` to sequence frames. Each frame completes with a per-requester acknowledge, or with an error pulse on timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, max `clk` cycles allowed in each of the LAUNCH and SEND phases (≥2).
- clk  in  1  system clock (same clock that feeds `uarttx`).
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req  in  NUM_REQ  request per requester; level, held until ack/err.
- req_data  in  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant; high from launch until ack/err.
- ack  out  NUM_REQ  one-cycle pulse on the granted bit when its frame completes.
- err  out  1  one-cycle pulse on timeout; the matching `gnt` bit falls in the same cycle.
- busy  out  1  high whenever state ≠ IDLE.
- tx_newd  out  1  drives the transmitter's `newd`.
- tx_data  out  8  drives the transmitter's `dintx`.
- tx_line  in  1  transmitter serial output `tx`; monitored for the start bit.
- tx_done  in  1  transmitter `donetx`.

## Operation
- States: IDLE, LAUNCH, SEND.
- IDLE:
  - If req is nonzero, select the first set bit searching from `ptr` upward, wrapping mod NUM_REQ.
  - Register `gnt`, set tx_data = that requester's byte, set tx_newd = 1, clear cnt, go to LAUNCH.
- LAUNCH:
  - If tx_line == 0 (start bit seen): tx_newd ← 0, cnt ← 0, go to SEND.
  - Else if cnt == TIMEOUT_CYCLES-1: abort.
  - Else cnt++.
- SEND:
  - On a tx_done rising edge (tx_done & ~tx_done_q): ack[granted] ← 1 for one cycle, gnt ← 0, ptr ← granted+1 mod NUM_REQ, go to IDLE.
  - Else if cnt == TIMEOUT_CYCLES-1: abort.
  - Else cnt++.
- Abort: err ← 1 for one cycle, gnt ← 0, tx_newd ← 0, ptr ← granted+1 mod NUM_REQ, go to IDLE. The pointer advances on error so a stuck requester cannot starve the others.
- tx_data is captured at grant and held constant until return to IDLE. Changes to req_data after grant are ignored.
- If a requester drops req while granted, the frame still completes and ack/err is still issued.
- cnt width is $clog2(TIMEOUT_CYCLES); counting saturates at the compare value.
- tx_done_q is a one-flop delayed copy of tx_done, updated every cycle.
- tx_line and tx_done are treated as synchronous to clk; no synchronizers.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, cnt = 0, tx_done_q = 0.
  - gnt = 0, ack = 0, err = 0, busy = 0, tx_newd = 0, tx_data = 8'h00.
- Reset asserted mid-frame: all outputs reach their reset values at the next clk edge. The frame in flight is abandoned with no ack and no err.
- Grant latency: req sampled high in IDLE at edge N means gnt, tx_newd and busy are high after edge N+1.
- tx_newd falls on the edge after tx_line is first sampled low.
- ack/err are asserted for exactly one cycle; state is IDLE in that same cycle.
- A new grant occurs at the earliest one cycle after ack/err, so there are ≥1 IDLE cycles between frames.
- Simultaneous requests: exactly one grant, chosen by round-robin from `ptr`. Others wait with no loss.
- With default clk_freq/baud_rate, one frame takes about 10 uclk periods (about 1060 clk cycles). This is well inside the default timeout.

## Test plan
- Single request: req=4'b0001, req_data[7:0]=8'hA5 → gnt=0001 one cycle later, tx_newd high until the start bit. Line carries A5 LSB-first; ack=0001 pulses once, busy falls, ptr=1.
- Contention: req=4'b1010 held, bytes 8'h3C (req1) and 8'hC3 (req3) → frames in order req1 then req3. Each acked once; no err.
- Fairness: all four req held continuously, bytes 8'h11/22/33/44 → grants cycle 0,1,2,3,0,…; bytes appear on the line in that order across 8 frames.
- Launch timeout: TIMEOUT_CYCLES=16, tx_line stub tied high, req=0100 → err pulses exactly 16 cycles after grant. gnt clears and tx_newd drops with it; no ack; next grant starts from requester 3.
- Reset mid-SEND: assert rst for 1 cycle during bit 4 of a frame → gnt/ack/err/busy/tx_newd become 0 the next cycle. No ack for the aborted frame; ptr=0.
- Request drop and data change after grant: req0 drops and req_data changes after the grant → the originally captured byte is transmitted and ack0 still pulses.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                              |
// | Brief   : Round-robin scheduler sharing one UART serializer among      |
// |           NUM_REQ byte producers, with launch/send timeouts.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic                 busy,
    output logic                 tx_newd,
    output logic [7:0]           tx_data,
    input  logic                 tx_line,
    input  logic                 tx_done
);

    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_PTR_W:0]   c_NUM_REQ  = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST_REQ = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_SEND   = 2'd2
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [c_PTR_W-1:0]   r_ptr_q,   w_ptr_d;
    logic [c_PTR_W-1:0]   r_gidx_q,  w_gidx_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [NUM_REQ-1:0]   r_gnt_q,   w_gnt_d;
    logic [NUM_REQ-1:0]   r_ack_q,   w_ack_d;
    logic                 r_err_q,   w_err_d;
    logic                 r_newd_q,  w_newd_d;
    logic [7:0]           r_data_q,  w_data_d;
    logic                 r_tx_done_q;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [c_PTR_W-1:0]   w_rr_off;
    logic [c_PTR_W:0]     w_rr_sum;
    logic [c_PTR_W-1:0]   w_rr_idx;
    logic [NUM_REQ-1:0]   w_rr_onehot;
    logic [7:0]           w_sel_byte;
    logic [c_PTR_W-1:0]   w_next_ptr;
    logic                 w_done_rise;
    logic                 w_abort;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    assign w_req_dbl = {req, req} >> r_ptr_q;
    assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

    always_comb begin
        w_rr_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_rr_off = c_PTR_W'(k);
            end
        end
    end

    assign w_rr_sum = {1'b0, r_ptr_q} + {1'b0, w_rr_off};
    assign w_rr_idx = (w_rr_sum >= c_NUM_REQ) ? c_PTR_W'(w_rr_sum - c_NUM_REQ)
                                              : c_PTR_W'(w_rr_sum);

    always_comb begin
        w_rr_onehot = '0;
        w_sel_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rr_idx == c_PTR_W'(i)) begin
                w_rr_onehot[i] = 1'b1;
                w_sel_byte     = req_data[8*i +: 8];
            end
        end
    end

    assign w_next_ptr  = (r_gidx_q == c_LAST_REQ) ? '0 : r_gidx_q + c_PTR_W'(1);
    assign w_done_rise = tx_done & ~r_tx_done_q;

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_gidx_d  = r_gidx_q;
        w_cnt_d   = r_cnt_q;
        w_gnt_d   = r_gnt_q;
        w_ack_d   = '0;
        w_err_d   = 1'b0;
        w_newd_d  = r_newd_q;
        w_data_d  = r_data_q;
        w_abort   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (|req) begin
                    w_gidx_d  = w_rr_idx;
                    w_gnt_d   = w_rr_onehot;
                    w_data_d  = w_sel_byte;
                    w_newd_d  = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!tx_line) begin
                    w_newd_d  = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = S_SEND;
                end else if (r_cnt_q == c_CNT_MAX) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            S_SEND: begin
                if (w_done_rise) begin
                    w_ack_d   = r_gnt_q;
                    w_gnt_d   = '0;
                    w_ptr_d   = w_next_ptr;
                    w_state_d = S_IDLE;
                end else if (r_cnt_q == c_CNT_MAX) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_d = r_cnt_q + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_gnt_d   = '0;
                w_newd_d  = 1'b0;
            end
        endcase

        // Advancing ptr on timeout keeps a stuck requester from starving others.
        if (w_abort) begin
            w_err_d   = 1'b1;
            w_gnt_d   = '0;
            w_newd_d  = 1'b0;
            w_ptr_d   = w_next_ptr;
            w_state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_ptr_q     <= '0;
            r_gidx_q    <= '0;
            r_cnt_q     <= '0;
            r_gnt_q     <= '0;
            r_ack_q     <= '0;
            r_err_q     <= 1'b0;
            r_newd_q    <= 1'b0;
            r_data_q    <= 8'h00;
            r_tx_done_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_gidx_q    <= w_gidx_d;
            r_cnt_q     <= w_cnt_d;
            r_gnt_q     <= w_gnt_d;
            r_ack_q     <= w_ack_d;
            r_err_q     <= w_err_d;
            r_newd_q    <= w_newd_d;
            r_data_q    <= w_data_d;
            r_tx_done_q <= tx_done;
        end
    end

    assign gnt     = r_gnt_q;
    assign ack     = r_ack_q;
    assign err     = r_err_q;
    assign busy    = (r_state_q != S_IDLE);
    assign tx_newd = r_newd_q;
    assign tx_data = r_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_uart_tx_arbiter                                           |
// | Brief   : Directed scoreboard bench for uart_tx_arbiter with a         |
// |           behavioural serializer stub (1 clk per bit).                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TO      = 16;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   ack;
    logic                 err;
    logic                 busy;
    logic                 tx_newd;
    logic [7:0]           tx_data;
    logic                 tx_line;
    logic                 tx_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        bit         is_err;
    } exp_t;
    exp_t sb[$];

    // Serializer stub state
    bit         stub_en;
    bit         stub_active;
    int         stub_bitn;
    logic [9:0] stub_sh;
    logic [7:0] sent_byte;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .tx_newd  (tx_newd),
        .tx_data  (tx_data),
        .tx_line  (tx_line),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub serializer: start bit, 8 data bits LSB first, stop bit, donetx pulse.
    initial begin
        tx_line     = 1'b1;
        tx_done     = 1'b0;
        stub_active = 1'b0;
        stub_bitn   = 0;
        stub_sh     = '1;
        sent_byte   = 8'h00;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                stub_active = 1'b0;
                tx_line     = 1'b1;
            end else if (!stub_active) begin
                if (stub_en && tx_newd) begin
                    stub_active = 1'b1;
                    sent_byte   = tx_data;
                    stub_sh     = {1'b1, tx_data, 1'b0};
                    stub_bitn   = 0;
                    tx_line     = 1'b0;
                end
            end else begin
                stub_bitn++;
                if (stub_bitn == 10) begin
                    stub_active = 1'b0;
                    tx_done     = 1'b1;
                    tx_line     = 1'b1;
                end else begin
                    tx_line = stub_sh[stub_bitn];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit e);
        exp_t x;
        x.idx    = i;
        x.data   = d;
        x.is_err = e;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits one frame, compares against the head of the scoreboard.
    task automatic do_frame(input bit drop, input bit tamper);
        exp_t               e;
        int                 n;
        bit                 seen_low;
        logic               newd_at_low;
        bit                 data_bad;
        logic [NUM_REQ-1:0] onehot;
        e           = sb.pop_front();
        onehot      = '0;
        onehot[e.idx] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 50);
        check("grant_latency", n, 1);
        check("gnt", gnt, onehot);
        check("tx_data_at_grant", tx_data, e.data);
        check("tx_newd_at_grant", tx_newd, 1);
        check("busy_at_grant", busy, 1);
        check("prev_pulse_width", {ack, err}, 0);
        if (tamper) begin
            req[e.idx] = 1'b0;
            set_byte(e.idx, ~e.data);
        end
        n           = 0;
        seen_low    = 1'b0;
        newd_at_low = 1'b1;
        data_bad    = 1'b0;
        while (ack == '0 && err == 1'b0 && n < 200) begin
            tick();
            n++;
            if (!seen_low && tx_line == 1'b0 && gnt != '0) begin
                seen_low    = 1'b1;
                newd_at_low = tx_newd;
            end
            if (gnt != '0 && tx_data !== e.data) data_bad = 1'b1;
        end
        check("frame_end_seen", (ack != '0) || err, 1);
        if (e.is_err) begin
            check("err", err, 1);
            check("ack_on_err", ack, 0);
            check("err_latency", n, TO);
            check("tx_newd_at_err", tx_newd, 0);
        end else begin
            check("ack", ack, onehot);
            check("err_on_ack", err, 0);
            check("line_byte", sent_byte, e.data);
            check("newd_fall_after_start", newd_at_low, 0);
        end
        check("gnt_clear", gnt, 0);
        check("busy_clear", busy, 0);
        check("tx_data_held", data_bad, 0);
        if (drop) req[e.idx] = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        stub_en  = 1'b1;
        tick();
        tick();
        check("reset_gnt", gnt, 0);
        check("reset_ack", ack, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        check("reset_tx_newd", tx_newd, 0);
        check("reset_tx_data", tx_data, 0);
        rst = 1'b0;
        tick();

        // Single request
        push(0, 8'hA5, 1'b0);
        set_byte(0, 8'hA5);
        req = 4'b0001;
        do_frame(1'b1, 1'b0);

        // Contention, ptr = 1
        push(1, 8'h3C, 1'b0);
        push(3, 8'hC3, 1'b0);
        set_byte(1, 8'h3C);
        set_byte(3, 8'hC3);
        req = 4'b1010;
        do_frame(1'b1, 1'b0);
        do_frame(1'b1, 1'b0);

        // Fairness, ptr = 0, all held
        set_byte(0, 8'h11);
        set_byte(1, 8'h22);
        set_byte(2, 8'h33);
        set_byte(3, 8'h44);
        for (int f = 0; f < 8; f++) push(f % 4, 8'h11 * (f % 4 + 1), 1'b0);
        req = 4'b1111;
        for (int f = 0; f < 8; f++) do_frame(1'b0, 1'b0);
        req = '0;

        // Launch timeout with a silent serializer, ptr = 0
        stub_en = 1'b0;
        push(2, 8'h5A, 1'b1);
        set_byte(2, 8'h5A);
        req = 4'b0100;
        do_frame(1'b1, 1'b0);
        stub_en = 1'b1;
        push(3, 8'h7E, 1'b0);
        push(0, 8'hE7, 1'b0);
        set_byte(3, 8'h7E);
        set_byte(0, 8'hE7);
        req = 4'b1001;
        do_frame(1'b1, 1'b0);
        do_frame(1'b1, 1'b0);

        // Request drop and data change after grant, ptr = 1
        push(0, 8'h96, 1'b0);
        set_byte(0, 8'h96);
        req = 4'b0001;
        do_frame(1'b0, 1'b1);

        // Reset in the middle of SEND
        set_byte(2, 8'h0F);
        req = 4'b0100;
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 50);
        check("rst_test_gnt", gnt, 4'b0100);
        n = 0;
        while (tx_newd && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) tick();
        check("rst_test_in_send", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        check("rst_mid_gnt", gnt, 0);
        check("rst_mid_ack", ack, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tx_newd", tx_newd, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack != '0 || err) seen = 1'b1;
        end
        check("no_pulse_after_reset", seen, 0);
        push(0, 8'hAA, 1'b0);
        push(1, 8'h55, 1'b0);
        set_byte(0, 8'hAA);
        set_byte(1, 8'h55);
        req = 4'b0011;
        do_frame(1'b1, 1'b0);
        do_frame(1'b1, 1'b0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
